// File: rtl/mm_sequencer.sv
// Operand sequencer for a 3x3 systolic matrix multiply: latches A rows and B columns on START and
// feeds them skewed into the PE array edges. Optional feed/drain freeze input under MM_SEQ_STALL_EN.
module mm_sequencer #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [3*WIDTH-1:0] A_ROW_1,
   input  logic [3*WIDTH-1:0] A_ROW_2,
   input  logic [3*WIDTH-1:0] A_ROW_3,
   input  logic [3*WIDTH-1:0] B_COL_1,
   input  logic [3*WIDTH-1:0] B_COL_2,
   input  logic [3*WIDTH-1:0] B_COL_3,
`ifdef MM_SEQ_STALL_EN
   input  logic               STALL,
`endif
   output logic [WIDTH-1:0]   A_FEED_1,
   output logic [WIDTH-1:0]   A_FEED_2,
   output logic [WIDTH-1:0]   A_FEED_3,
   output logic [WIDTH-1:0]   B_FEED_1,
   output logic [WIDTH-1:0]   B_FEED_2,
   output logic [WIDTH-1:0]   B_FEED_3,
   output logic               PE_CLEAR,
   output logic               PE_EN,
   output logic               BUSY,
   output logic               DONE
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StClear = 3'd1,
      StFeed  = 3'd2,
      StDrain = 3'd3,
      StFin   = 3'd4
   } state_e;

   localparam logic [2:0] LastStep  = 3'd4;
   localparam logic [3:0] LastDrain = 4'(DRAIN_CYCLES - 1);

   state_e             state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic [3:0]         drain_q, drain_d;
   logic               load;
   logic               stall_act;
   logic [3*WIDTH-1:0] a_lat_q [3];
   logic [3*WIDTH-1:0] b_lat_q [3];
   logic [WIDTH-1:0]   a_feed [3];
   logic [WIDTH-1:0]   b_feed [3];

`ifdef MM_SEQ_STALL_EN
   assign stall_act = STALL && ((state_q == StFeed) || (state_q == StDrain));
`else
   assign stall_act = 1'b0;
`endif

   // Element 0 sits in the most significant slice.
   function automatic logic [WIDTH-1:0] pick(input logic [3*WIDTH-1:0] v, input logic [2:0] j);
      case (j)
         3'd0:    pick = v[3*WIDTH-1 -: WIDTH];
         3'd1:    pick = v[2*WIDTH-1 -: WIDTH];
         3'd2:    pick = v[WIDTH-1:0];
         default: pick = '0;
      endcase
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         step_q  <= '0;
         drain_q <= '0;
         for (int i = 0; i < 3; i++) begin
            a_lat_q[i] <= '0;
            b_lat_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         drain_q <= drain_d;
         if (load) begin
            a_lat_q[0] <= A_ROW_1;
            a_lat_q[1] <= A_ROW_2;
            a_lat_q[2] <= A_ROW_3;
            b_lat_q[0] <= B_COL_1;
            b_lat_q[1] <= B_COL_2;
            b_lat_q[2] <= B_COL_3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      drain_d = drain_q;
      load    = 1'b0;
      case (state_q)
         StIdle: begin
            if (START) begin
               load    = 1'b1;
               state_d = StClear;
            end
         end
         StClear: begin
            step_d  = '0;
            state_d = StFeed;
         end
         StFeed: begin
            if (!stall_act) begin
               if (step_q == LastStep) begin
                  step_d  = '0;
                  drain_d = '0;
                  state_d = StDrain;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         StDrain: begin
            if (!stall_act) begin
               if (drain_q == LastDrain) begin
                  drain_d = '0;
                  state_d = StFin;
               end else begin
                  drain_d = drain_q + 4'd1;
               end
            end
         end
         StFin: state_d = StIdle;
         default: begin
            state_d = StIdle;
            step_d  = '0;
            drain_d = '0;
         end
      endcase
   end

   always_comb begin
      PE_CLEAR = 1'b0;
      PE_EN    = 1'b0;
      BUSY     = 1'b0;
      DONE     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_feed[i] = '0;
         b_feed[i] = '0;
      end
      case (state_q)
         StClear: begin
            PE_CLEAR = 1'b1;
            BUSY     = 1'b1;
         end
         StFeed: begin
            BUSY = 1'b1;
            if (!stall_act) begin
               PE_EN = 1'b1;
               // Row/column i lags by i steps to form the systolic wavefront.
               for (int i = 0; i < 3; i++) begin
                  if (step_q >= 3'(i)) begin
                     a_feed[i] = pick(a_lat_q[i], step_q - 3'(i));
                     b_feed[i] = pick(b_lat_q[i], step_q - 3'(i));
                  end
               end
            end
         end
         StDrain: begin
            BUSY  = 1'b1;
            PE_EN = !stall_act;
         end
         StFin:   DONE = 1'b1;
         default: ;
      endcase
   end

   assign A_FEED_1 = a_feed[0];
   assign A_FEED_2 = a_feed[1];
   assign A_FEED_3 = a_feed[2];
   assign B_FEED_1 = b_feed[0];
   assign B_FEED_2 = b_feed[1];
   assign B_FEED_3 = b_feed[2];

endmodule
